// File: rtl/sad_min_reduce_if.sv
// rtl/sad_min_reduce_if.sv - EX7 lane-batch bus carried from the EX6/EX7 pipeline register
interface sad_min_reduce_if #(
  parameter int DATA_W  = 32,
  parameter int COORD_W = 32
);
  logic               Valid_EX7;
  logic               Last_EX7;
  logic [DATA_W-1:0]  sOut1_EX7;
  logic [DATA_W-1:0]  sOut2_EX7;
  logic [DATA_W-1:0]  sOut3_EX7;
  logic [DATA_W-1:0]  sOut4_EX7;
  logic [DATA_W-1:0]  sOut5_EX7;
  logic [DATA_W-1:0]  sOut6_EX7;
  logic [DATA_W-1:0]  sOut7_EX7;
  logic [DATA_W-1:0]  sOut8_EX7;
  logic [COORD_W-1:0] BaseX_EX7;
  logic [COORD_W-1:0] BaseY_EX7;

  modport master (
    output Valid_EX7, Last_EX7,
    output sOut1_EX7, sOut2_EX7, sOut3_EX7, sOut4_EX7,
    output sOut5_EX7, sOut6_EX7, sOut7_EX7, sOut8_EX7,
    output BaseX_EX7, BaseY_EX7
  );

  modport slave (
    input Valid_EX7, Last_EX7,
    input sOut1_EX7, sOut2_EX7, sOut3_EX7, sOut4_EX7,
    input sOut5_EX7, sOut6_EX7, sOut7_EX7, sOut8_EX7,
    input BaseX_EX7, BaseY_EX7
  );
endinterface

// File: rtl/sad_min_reduce.sv
// rtl/sad_min_reduce.sv - registered 8-lane SAD minimum tree with running frame-best merge
module sad_min_reduce #(
  parameter int DATA_W  = 32,
  parameter int COORD_W = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Stall,
  sad_min_reduce_if.slave     ex7,
  output logic [DATA_W-1:0]   BestSad,
  output logic [COORD_W-1:0]  BestX,
  output logic [COORD_W-1:0]  BestY,
  output logic                Done,
  output logic                Busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  best_sad_q;
  logic [COORD_W-1:0] best_x_q;
  logic [COORD_W-1:0] best_y_q;
  logic               done_q;

  logic [DATA_W-1:0]  lane_sad [8];
  logic [COORD_W-1:0] lane_x   [8];

  logic [DATA_W-1:0]  s1_sad_d [4];
  logic [COORD_W-1:0] s1_x_d   [4];
  logic [DATA_W-1:0]  s1_sad_q [4];
  logic [COORD_W-1:0] s1_x_q   [4];
  logic [COORD_W-1:0] s1_y_q;
  logic               s1_vld_q, s1_last_q;

  logic [DATA_W-1:0]  s2_sad_d [2];
  logic [COORD_W-1:0] s2_x_d   [2];
  logic [DATA_W-1:0]  s2_sad_q [2];
  logic [COORD_W-1:0] s2_x_q   [2];
  logic [COORD_W-1:0] s2_y_q;
  logic               s2_vld_q, s2_last_q;

  logic [DATA_W-1:0]  s3_sad_d;
  logic [COORD_W-1:0] s3_x_d;
  logic [DATA_W-1:0]  s3_sad_q;
  logic [COORD_W-1:0] s3_x_q;
  logic [COORD_W-1:0] s3_y_q;
  logic               s3_vld_q, s3_last_q;

  logic accept;
  logic merge_upd;
  logic last_merge;

  // Unpack the lane bus; lane k sits k columns to the right of BaseX (wrapping)
  always_comb begin
    lane_sad[0] = ex7.sOut1_EX7;
    lane_sad[1] = ex7.sOut2_EX7;
    lane_sad[2] = ex7.sOut3_EX7;
    lane_sad[3] = ex7.sOut4_EX7;
    lane_sad[4] = ex7.sOut5_EX7;
    lane_sad[5] = ex7.sOut6_EX7;
    lane_sad[6] = ex7.sOut7_EX7;
    lane_sad[7] = ex7.sOut8_EX7;
    for (int k = 0; k < 8; k++) begin
      lane_x[k] = ex7.BaseX_EX7 + COORD_W'(k);
    end
  end

  // Comparator levels: the higher-numbered side wins only when strictly smaller
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (lane_sad[2*i+1] < lane_sad[2*i]) begin
        s1_sad_d[i] = lane_sad[2*i+1];
        s1_x_d[i]   = lane_x[2*i+1];
      end else begin
        s1_sad_d[i] = lane_sad[2*i];
        s1_x_d[i]   = lane_x[2*i];
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (s1_sad_q[2*i+1] < s1_sad_q[2*i]) begin
        s2_sad_d[i] = s1_sad_q[2*i+1];
        s2_x_d[i]   = s1_x_q[2*i+1];
      end else begin
        s2_sad_d[i] = s1_sad_q[2*i];
        s2_x_d[i]   = s1_x_q[2*i];
      end
    end
    if (s2_sad_q[1] < s2_sad_q[0]) begin
      s3_sad_d = s2_sad_q[1];
      s3_x_d   = s2_x_q[1];
    end else begin
      s3_sad_d = s2_sad_q[0];
      s3_x_d   = s2_x_q[0];
    end
  end

  assign accept     = ex7.Valid_EX7 && (state_q == RUN);
  assign merge_upd  = s3_vld_q && (s3_sad_q < best_sad_q);
  assign last_merge = s3_vld_q && s3_last_q;

  // Tree pipeline: Start flushes in-flight batches but may load a new first batch
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s3_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s2_last_q <= 1'b0;
      s3_last_q <= 1'b0;
    end else if (Start || !Stall) begin
      s1_vld_q  <= Start ? ex7.Valid_EX7 : accept;
      s1_last_q <= ex7.Last_EX7;
      s1_sad_q  <= s1_sad_d;
      s1_x_q    <= s1_x_d;
      s1_y_q    <= ex7.BaseY_EX7;
      s2_vld_q  <= s1_vld_q && !Start;
      s2_last_q <= s1_last_q;
      s2_sad_q  <= s2_sad_d;
      s2_x_q    <= s2_x_d;
      s2_y_q    <= s1_y_q;
      s3_vld_q  <= s2_vld_q && !Start;
      s3_last_q <= s2_last_q;
      s3_sad_q  <= s3_sad_d;
      s3_x_q    <= s3_x_d;
      s3_y_q    <= s2_y_q;
    end
  end

  // Frame control and merge into the running best; Done pulses on the last merge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      best_sad_q <= '1;
      best_x_q   <= '0;
      best_y_q   <= '0;
      done_q     <= 1'b0;
    end else if (Start) begin
      best_sad_q <= '1;
      best_x_q   <= '0;
      best_y_q   <= '0;
      done_q     <= 1'b0;
      state_q    <= (ex7.Valid_EX7 && ex7.Last_EX7) ? DRAIN : RUN;
    end else if (Stall) begin
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (merge_upd) begin
        best_sad_q <= s3_sad_q;
        best_x_q   <= s3_x_q;
        best_y_q   <= s3_y_q;
      end
      case (state_q)
        RUN: begin
          if (accept && ex7.Last_EX7) state_q <= DRAIN;
        end
        DRAIN: begin
          if (last_merge) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BestSad = best_sad_q;
  assign BestX   = best_x_q;
  assign BestY   = best_y_q;
  assign Done    = done_q;
  assign Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sad_min_reduce.sv
// tb/tb_sad_min_reduce.sv - scoreboard bench for sad_min_reduce with a frame-level reference model
module tb_sad_min_reduce;
  localparam int DW = 32;
  localparam int CW = 32;

  logic Clk = 1'b0;
  logic Reset, Start, Stall;
  logic [DW-1:0] BestSad;
  logic [CW-1:0] BestX, BestY;
  logic Done, Busy;

  always #5 Clk = ~Clk;

  sad_min_reduce_if #(.DATA_W(DW), .COORD_W(CW)) bus ();

  sad_min_reduce #(.DATA_W(DW), .COORD_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .ex7(bus),
    .BestSad(BestSad), .BestX(BestX), .BestY(BestY), .Done(Done), .Busy(Busy)
  );

  typedef struct packed {
    logic [7:0][31:0] s;
    logic [31:0]      bx;
    logic [31:0]      by;
  } batch_t;

  typedef struct {
    logic [31:0] sad;
    logic [31:0] x;
    logic [31:0] y;
    int          done_cyc;
  } exp_t;

  exp_t   sb[$];
  batch_t fb[$];
  bit     fixed_drain[$];
  exp_t   mon_e;
  exp_t   last_exp;
  int     checks = 0, errors = 0, cyc = 0, dones_seen = 0, frames_exp = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic batch_t mk(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7, bx, by);
    batch_t b;
    b.s[0] = a0; b.s[1] = a1; b.s[2] = a2; b.s[3] = a3;
    b.s[4] = a4; b.s[5] = a5; b.s[6] = a6; b.s[7] = a7;
    b.bx = bx; b.by = by;
    return b;
  endfunction

  function automatic batch_t rand_batch();
    batch_t b;
    bit big = ($urandom_range(0, 3) == 0);
    for (int k = 0; k < 8; k++) b.s[k] = big ? $urandom : 32'($urandom_range(0, 20));
    b.bx = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
    b.by = $urandom;
    return b;
  endfunction

  // Garbage used whenever the DUT must ignore the bus: zero SADs would win if taken
  function automatic batch_t junk();
    batch_t b;
    for (int k = 0; k < 8; k++) b.s[k] = 32'd0;
    b.bx = $urandom; b.by = $urandom;
    return b;
  endfunction

  task automatic drive(input batch_t b, input bit v, input bit l);
    bus.Valid_EX7 = v; bus.Last_EX7 = l;
    bus.sOut1_EX7 = b.s[0]; bus.sOut2_EX7 = b.s[1];
    bus.sOut3_EX7 = b.s[2]; bus.sOut4_EX7 = b.s[3];
    bus.sOut5_EX7 = b.s[4]; bus.sOut6_EX7 = b.s[5];
    bus.sOut7_EX7 = b.s[6]; bus.sOut8_EX7 = b.s[7];
    bus.BaseX_EX7 = b.bx;   bus.BaseY_EX7 = b.by;
  endtask

  // Reference: scan every lane of every batch in arrival order, keep the first strict minimum
  task automatic model_frame(output exp_t e);
    e.sad = 32'hFFFF_FFFF; e.x = 0; e.y = 0; e.done_cyc = 0;
    foreach (fb[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (fb[i].s[k] < e.sad) begin
          e.sad = fb[i].s[k];
          e.x   = fb[i].bx + 32'(k);
          e.y   = fb[i].by;
        end
      end
    end
  endtask

  task automatic run_frame(input bit start_valid, input int stall_pct, input int bubble_pct);
    int n = fb.size();
    int idx = 0;
    int e = 0;
    int adv = 0;
    bit st, v;
    bit pat[$];
    exp_t ex;
    model_frame(ex);
    @(negedge Clk);
    Start = 1'b1;
    Stall = 1'($urandom_range(0, 1));
    if (start_valid) begin
      drive(fb[0], 1'b1, n == 1);
      idx = 1;
      e = cyc + 1;
    end else begin
      drive(junk(), 1'b0, 1'b1);
    end
    @(negedge Clk);
    check("start_clear_sad", BestSad, 32'hFFFF_FFFF);
    check("start_clear_x", BestX, 0);
    check("start_busy", Busy, 1);
    Start = 1'b0;
    while (idx < n) begin
      st = ($urandom_range(0, 99) < stall_pct);
      v  = st ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 99) >= bubble_pct);
      Stall = st;
      if (v) drive(fb[idx], 1'b1, idx == n - 1);
      else   drive(junk(), 1'b0, 1'b1);
      if (v && !st) begin
        e = cyc + 1;
        idx++;
      end
      @(negedge Clk);
    end
    if (fixed_drain.size() > 0) begin
      pat = fixed_drain;
    end else begin
      while (adv < 3) begin
        st = ($urandom_range(0, 99) < stall_pct);
        pat.push_back(st);
        if (!st) adv++;
      end
    end
    ex.done_cyc = e + pat.size();
    sb.push_back(ex);
    frames_exp++;
    foreach (pat[j]) begin
      Stall = pat[j];
      drive(junk(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge Clk);
    end
    Stall = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive(junk(), 1'b1, 1'($urandom_range(0, 1)));
      @(negedge Clk);
    end
    check("idle_hold_sad", BestSad, ex.sad);
    check("idle_hold_x", BestX, ex.x);
    check("idle_hold_y", BestY, ex.y);
    check("idle_busy", Busy, 0);
    last_exp = ex;
  endtask

  // Monitor: every Done must match the oldest outstanding frame expectation
  always @(negedge Clk) begin
    if (Reset === 1'b0 && Done === 1'b1) begin
      dones_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: Done=1 at cycle %0d, required no Done", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_sad", BestSad, mon_e.sad);
        check("done_x", BestX, mon_e.x);
        check("done_y", BestY, mon_e.y);
        check("done_cycle", cyc, mon_e.done_cyc);
        check("done_busy", Busy, 0);
      end
    end
  end

  initial begin
    Reset = 1'b1; Start = 1'($urandom_range(0, 1)); Stall = 1'($urandom_range(0, 1));
    drive(rand_batch(), 1'b1, 1'b1);
    @(negedge Clk);
    drive(rand_batch(), 1'b1, 1'b0);
    @(negedge Clk);
    check("reset_sad", BestSad, 32'hFFFF_FFFF);
    check("reset_x", BestX, 0);
    check("reset_y", BestY, 0);
    check("reset_done", Done, 0);
    check("reset_busy", Busy, 0);
    Reset = 1'b0; Start = 1'b0; Stall = 1'b0;

    for (int j = 0; j < 6; j++) begin
      drive(junk(), 1'b1, 1'($urandom_range(0, 1)));
      @(negedge Clk);
    end
    check("idle_ignore_sad", BestSad, 32'hFFFF_FFFF);
    check("idle_ignore_busy", Busy, 0);

    fb = '{mk(50, 40, 30, 20, 25, 35, 45, 55, 10, 3)};
    run_frame(1'b0, 0, 0);
    check("single_sad", BestSad, 20);
    check("single_x", BestX, 13);

    fixed_drain = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    run_frame(1'b0, 0, 0);
    fixed_drain.delete();

    fb = '{mk(7, 7, 7, 7, 7, 7, 7, 7, 100, 1), mk(9, 9, 7, 9, 7, 9, 9, 9, 200, 1)};
    run_frame(1'b0, 0, 0);
    fb.push_back(mk(50, 50, 50, 6, 50, 50, 50, 50, 300, 2));
    run_frame(1'b0, 0, 0);

    fb = '{mk(100, 90, 95, 99, 91, 92, 93, 94, 40, 7),
           mk(30, 20, 15, 16, 17, 18, 19, 21, 50, 8),
           mk(60, 61, 62, 63, 64, 65, 66, 67, 60, 9)};
    run_frame(1'b0, 0, 0);

    fb = '{mk(9, 9, 9, 2, 9, 9, 9, 9, 32'hFFFF_FFFE, 5)};
    run_frame(1'b0, 0, 0);
    check("wrap_x", BestX, 32'h0000_0001);

    fb = '{rand_batch(), rand_batch()};
    run_frame(1'b1, 0, 0);

    // Restart with two batches in flight: they must vanish without a Done
    @(negedge Clk);
    Start = 1'b1; drive(junk(), 1'b0, 1'b0);
    @(negedge Clk);
    Start = 1'b0; drive(mk(1, 1, 1, 1, 1, 1, 1, 1, 5, 5), 1'b1, 1'b0);
    @(negedge Clk);
    drive(mk(2, 2, 2, 2, 2, 2, 2, 2, 6, 6), 1'b1, 1'b0);
    @(negedge Clk);
    Start = 1'b1; drive(junk(), 1'b0, 1'b0);
    @(negedge Clk);
    Start = 1'b0;
    check("abort_sad", BestSad, 32'hFFFF_FFFF);
    check("abort_busy", Busy, 1);
    for (int j = 0; j < 6; j++) @(negedge Clk);
    check("abort_discard_sad", BestSad, 32'hFFFF_FFFF);

    for (int f = 0; f < 40; f++) begin
      fb.delete();
      for (int b = 0; b < int'($urandom_range(1, 5)); b++) fb.push_back(rand_batch());
      run_frame(($urandom_range(0, 3) == 0), 20, 25);
    end

    for (int j = 0; j < 5; j++) @(negedge Clk);
    check("pending_done", sb.size(), 0);
    check("done_count", dones_seen, frames_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
